// File: rtl/fpu_wb_bridge_if.sv
// fpu_wb_bridge_if
// Groups the Wishbone slave bus (wbs_*), the FPU command/result handshake
// (fpu_*) and the interrupt line of the FPU Wishbone bridge.
//   slave  : view taken by the bridge (receives Wishbone, drives the FPU).
//   master : opposite view (management bus + FPU core side).
// Parameters: DATA_W operand/result width, OP_W opcode width.
interface fpu_wb_bridge_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  logic              fpu_valid_o;
  logic              fpu_ready_i;
  logic [OP_W-1:0]   fpu_op_o;
  logic [2:0]        fpu_rm_o;
  logic [DATA_W-1:0] fpu_a_o;
  logic [DATA_W-1:0] fpu_b_o;
  logic              fpu_done_i;
  logic [DATA_W-1:0] fpu_result_i;
  logic [4:0]        fpu_flags_i;

  logic              irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output fpu_valid_o, fpu_op_o, fpu_rm_o, fpu_a_o, fpu_b_o,
    input  fpu_ready_i, fpu_done_i, fpu_result_i, fpu_flags_i,
    output irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  fpu_valid_o, fpu_op_o, fpu_rm_o, fpu_a_o, fpu_b_o,
    output fpu_ready_i, fpu_done_i, fpu_result_i, fpu_flags_i,
    input  irq_o
  );
endinterface

// File: rtl/fpu_wb_bridge.sv
// fpu_wb_bridge
// Wishbone-mapped command/result front end for the FPU core. Commands
// {op,rm,OPA,OPB} queue in a DEPTH-entry FIFO and issue one at a time over a
// valid/ready handshake; {result,flags} queue in a second FIFO with a level
// interrupt to the management core.
// Ports:
//   wb_clk_i  sole clock
//   wb_rst_i  asynchronous active-high reset
//   bus       fpu_wb_bridge_if.slave: wbs_* Wishbone slave, fpu_* command
//             and result handshake, irq_o level interrupt
// Register map (adr[4:2]): 0 OPA, 1 OPB, 2 CMD, 3 RESULT (pop), 4 STATUS,
//   5 CTRL, 6 FLAGS, 7 reserved.
// Optional feature macro: FPU_BRIDGE_TIMEOUT_EN -- WAIT gives up after
//   TIMEOUT cycles, returning 0x7FC00000 / NV and setting sticky TMO.
module fpu_wb_bridge #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  fpu_wb_bridge_if.slave   bus
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned CMD_W = OP_W + 3 + 2 * DATA_W;
  localparam int unsigned RES_W = DATA_W + 5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t            state_q;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic              irq_en_q, irq_q;
  logic              ovf_q, unf_q, tmo_q;
  logic [4:0]        flags_q;

  logic              fpu_valid_q;
  logic [OP_W-1:0]   fpu_op_q;
  logic [2:0]        fpu_rm_q;
  logic [DATA_W-1:0] fpu_a_q, fpu_b_q;
  logic [DATA_W-1:0] res_cap_q;
  logic [4:0]        flg_cap_q;

  logic [CMD_W-1:0]  cmd_mem_q [DEPTH];
  logic [PW-1:0]     cmd_wp_q, cmd_rp_q;
  logic [CW-1:0]     cmd_cnt_q;
  logic [RES_W-1:0]  res_mem_q [DEPTH];
  logic [PW-1:0]     res_wp_q, res_rp_q;
  logic [CW-1:0]     res_cnt_q;

  // Bus decode
  logic        wb_req, wb_wr, wb_rd;
  logic [2:0]  reg_sel;
  logic        cmd_wr, res_rd, st_wr;
  assign wb_req  = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign wb_wr   = wb_req & bus.wbs_we_i;
  assign wb_rd   = wb_req & ~bus.wbs_we_i;
  assign reg_sel = bus.wbs_adr_i[4:2];
  assign cmd_wr  = wb_wr & (reg_sel == 3'd2);
  assign res_rd  = wb_rd & (reg_sel == 3'd3);
  assign st_wr   = wb_wr & (reg_sel == 3'd4);

  // FIFO status and transfer strobes
  logic cmd_full, cmd_empty, res_full, res_empty;
  logic cmd_push, cmd_pop, res_push, res_pop;
  logic [CMD_W-1:0] cmd_head;
  logic [RES_W-1:0] res_head;
  assign cmd_full  = (cmd_cnt_q == CW'(DEPTH));
  assign cmd_empty = (cmd_cnt_q == '0);
  assign res_full  = (res_cnt_q == CW'(DEPTH));
  assign res_empty = (res_cnt_q == '0);
  assign cmd_head  = cmd_mem_q[cmd_rp_q];
  assign res_head  = res_mem_q[res_rp_q];
  assign cmd_push  = cmd_wr & ~cmd_full;
  assign cmd_pop   = (state_q == S_ISSUE) & fpu_valid_q & bus.fpu_ready_i;
  assign res_pop   = res_rd & ~res_empty;
  // A pop in the same cycle frees a slot, so a full result FIFO still
  // accepts the WB push.
  assign res_push  = (state_q == S_WB) & (~res_full | res_pop);

  logic tmo_hit;
`ifdef FPU_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] tmo_cnt_q;
  // tmo_cnt_q holds the number of completed WAIT cycles; the TIMEOUT-th one
  // ends the wait unless fpu_done_i arrives on it.
  assign tmo_hit = (state_q == S_WAIT) & ~bus.fpu_done_i &
                   (tmo_cnt_q == TW'(TIMEOUT - 1));
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                tmo_cnt_q <= '0;
    else if (state_q != S_WAIT)  tmo_cnt_q <= '0;
    else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = TIMEOUT[0];
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.wbs_sel_i, bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0],
                        bus.wbs_dat_i};

  // Read mux
  logic [31:0] status, rdata;
  always_comb begin
    status        = '0;
    status[3:0]   = 4'(cmd_cnt_q);
    status[7:4]   = 4'(res_cnt_q);
    status[8]     = (state_q != S_IDLE);
    status[9]     = cmd_full;
    status[10]    = res_empty;
    status[16]    = ovf_q;
    status[17]    = unf_q;
    status[18]    = tmo_q;
    rdata         = '0;
    case (reg_sel)
      3'd0:    rdata = 32'(opa_q);
      3'd1:    rdata = 32'(opb_q);
      3'd3:    if (!res_empty) rdata = 32'(res_head[RES_W-1:5]);
      3'd4:    rdata = status;
      3'd5:    rdata = {31'b0, irq_en_q};
      3'd6:    rdata = {27'b0, flags_q};
      default: rdata = '0;
    endcase
  end

  // Bus-side registers, stickies and interrupt
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      ack_q <= wb_req;
      dat_q <= wb_rd ? rdata : '0;
      if (wb_wr && reg_sel == 3'd0) opa_q <= DATA_W'(bus.wbs_dat_i);
      if (wb_wr && reg_sel == 3'd1) opb_q <= DATA_W'(bus.wbs_dat_i);
      if (wb_wr && reg_sel == 3'd5) irq_en_q <= bus.wbs_dat_i[0];
      if (res_pop) flags_q <= res_head[4:0];
      ovf_q <= (ovf_q & ~(st_wr & bus.wbs_dat_i[16])) | (cmd_wr & cmd_full);
      unf_q <= (unf_q & ~(st_wr & bus.wbs_dat_i[17])) | (res_rd & res_empty);
      tmo_q <= (tmo_q & ~(st_wr & bus.wbs_dat_i[18])) | tmo_hit;
      irq_q <= irq_en_q & ((res_cnt_q != '0) | ovf_q | unf_q | tmo_q);
    end
  end

  // Command FIFO
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) cmd_mem_q[i] <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem_q[cmd_wp_q] <= {bus.wbs_dat_i[OP_W-1:0], bus.wbs_dat_i[6:4],
                                opa_q, opb_q};
        cmd_wp_q <= cmd_wp_q + 1'b1;
      end
      if (cmd_pop) cmd_rp_q <= cmd_rp_q + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
        2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase
    end
  end

  // Result FIFO
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      res_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) res_mem_q[i] <= '0;
    end else begin
      if (res_push) begin
        res_mem_q[res_wp_q] <= {res_cap_q, flg_cap_q};
        res_wp_q <= res_wp_q + 1'b1;
      end
      if (res_pop) res_rp_q <= res_rp_q + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
        2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  // Issue FSM. Operands are loaded on IDLE->ISSUE and valid rises one cycle
  // later, so fpu_* are already stable when valid is first seen.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      fpu_valid_q <= 1'b0;
      fpu_op_q    <= '0;
      fpu_rm_q    <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      res_cap_q   <= '0;
      flg_cap_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!cmd_empty) begin
            state_q  <= S_ISSUE;
            fpu_op_q <= cmd_head[CMD_W-1 -: OP_W];
            fpu_rm_q <= cmd_head[2*DATA_W +: 3];
            fpu_a_q  <= cmd_head[DATA_W +: DATA_W];
            fpu_b_q  <= cmd_head[DATA_W-1:0];
          end
        end
        S_ISSUE: begin
          if (!fpu_valid_q) begin
            fpu_valid_q <= 1'b1;
          end else if (bus.fpu_ready_i) begin
            fpu_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.fpu_done_i) begin
            res_cap_q <= bus.fpu_result_i;
            flg_cap_q <= bus.fpu_flags_i;
            state_q   <= S_WB;
          end else if (tmo_hit) begin
            res_cap_q <= DATA_W'(32'h7FC0_0000);
            flg_cap_q <= 5'b10000;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          if (res_push) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o   = ack_q;
  assign bus.wbs_dat_o   = dat_q;
  assign bus.fpu_valid_o = fpu_valid_q;
  assign bus.fpu_op_o    = fpu_op_q;
  assign bus.fpu_rm_o    = fpu_rm_q;
  assign bus.fpu_a_o     = fpu_a_q;
  assign bus.fpu_b_o     = fpu_b_q;
  assign bus.irq_o       = irq_q;

endmodule

// File: doc/fpu_wb_bridge.md
# fpu_wb_bridge

Wishbone-mapped command/result front end for the user-area FPU core. Successor to the LA/IO-sliced FPU hookup: operands and opcodes arrive over the Caravel management Wishbone instead of fixed logic-analyzer bit ranges. Commands queue in a parametrised FIFO and issue one at a time to the FPU through a valid/ready handshake. Results and exception flags queue in a second FIFO, with a level interrupt to the management core. The bridge sits in user_project_wrapper between the wbs_* bus and the FPU core.

## Interface
Parameters:
- DATA_W, 32: operand/result width
- DEPTH, 4: entries in the command FIFO and in the result FIFO; power of two, ≥2
- OP_W, 3: opcode width
- TIMEOUT, 255: maximum cycles in WAIT (used only with FPU_BRIDGE_TIMEOUT_EN)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle/strobe/write
- wbs_sel_i  in  4  byte selects; ignored, full-word access only
- wbs_adr_i  in  32  address; only adr[4:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  read data
- fpu_valid_o  out  1  command valid to FPU
- fpu_ready_i  in  1  FPU accepts command
- fpu_op_o  out  OP_W  opcode
- fpu_rm_o  out  3  rounding mode
- fpu_a_o, fpu_b_o  out  DATA_W  operands
- fpu_done_i  in  1  one-cycle result strobe
- fpu_result_i  in  DATA_W  result
- fpu_flags_i  in  5  NV,DZ,OF,UF,NX
- irq_o  out  1  level interrupt

## Operation
Register map, byte offsets:
- 0x00 OPA (RW), 0x04 OPB (RW).
- 0x08 CMD (W): bits [OP_W-1:0]=op, [6:4]=rm. A write pushes {op,rm,OPA,OPB} into the command FIFO. If the FIFO is full: no push, sticky OVF set, still acked.
- 0x0C RESULT (R): returns the result FIFO head and pops it. FLAGS latches the entry's flags. If the FIFO is empty: returns 0, no pop, sticky UNF set.
- 0x10 STATUS (R): [3:0] cmd_count, [7:4] res_count, [8] busy (FSM≠IDLE), [9] cmd_full, [10] res_empty, [16] OVF, [17] UNF, [18] TMO. Writing 1 to bits 16–18 clears them.
- 0x14 CTRL (RW): [0] irq_en.
- 0x18 FLAGS (R): [4:0] flags of the last popped result.
- 0x1C: reads 0, writes ignored.

Issue FSM:
- IDLE→ISSUE when the command FIFO is non-empty. The head drives fpu_* and fpu_valid_o=1.
- ISSUE→WAIT on fpu_valid_o&fpu_ready_i. Pop the command FIFO on that edge. fpu_op/rm/a/b hold stable while valid is high.
- WAIT→WB on fpu_done_i. Capture result and flags.
- WB: push {result,flags} into the result FIFO, then go to IDLE. If the result FIFO is full, stall in WB.

Other rules:
- fpu_done_i outside WAIT is ignored.
- A simultaneous push and pop on either FIFO is legal; the count is unchanged.
- A WB push and a RESULT pop in the same cycle are both honoured, even when the FIFO is full.
- FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH, plus a separate count of log2(DEPTH)+1 bits.
- irq_o (registered) = irq_en & (res_count≠0 | OVF | UNF | TMO).

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, fpu_valid_o=0, fpu_op/rm/a/b=0, irq_o=0. All registers, FIFOs, stickies and counters clear; FSM=IDLE.
- Reset mid-operation aborts any in-flight command; a later fpu_done_i is ignored.
- A request is accepted at edge k when cyc&stb&!wbs_ack_o. Its write/pop effect happens at edge k. wbs_ack_o and wbs_dat_o are valid for exactly one cycle after edge k. Maximum rate is one access every 2 cycles.
- A CMD written at edge k raises fpu_valid_o at the earliest after edge k+2 (FIFO write, then IDLE→ISSUE).
- A fpu_done_i at edge d makes the result visible in res_count after edge d+1 (WB push). irq_o rises after edge d+2.

## Configuration
- FPU_BRIDGE_TIMEOUT_EN defined:
  - An 8+ bit counter runs in WAIT.
  - After TIMEOUT cycles without fpu_done_i, the FSM goes to WB with result 0x7FC00000 and flags 5'b10000.
  - Sticky TMO is set.
  - fpu_valid_o is already low.
- Macro undefined: WAIT waits indefinitely, the counter is absent and TMO reads 0.

## Test plan
- Reset with traffic pending: assert wb_rst_i while in WAIT → all outputs 0, STATUS reads 0x400, and a subsequent fpu_done_i leaves res_count=0.
- Single add: OPA=0x3FC00000, OPB=0x40100000, CMD=0x00 → fpu_a_o/fpu_b_o/fpu_op_o match, held until ready. The model returns 0x40700000 with flags 0 after 5 cycles → RESULT reads 0x40700000, FLAGS=0, irq_o falls after the pop.
- Backpressure: fpu_ready_i low for 10 cycles → fpu_valid_o stays high, operands stable, cmd_count=1 throughout.
- Overflow and full: with ready held low, write CMD 6 times (DEPTH=4) → cmd_count=4 and STATUS[16]=1. Then issue 4 results with RESULT unread → the 5th stalls in WB until a RESULT pop.
- Empty read: RESULT read with res_count=0 → returns 0 and UNF=1. Writing 0x20000 to STATUS clears UNF.
- Timeout (macro on, TIMEOUT=20): never assert fpu_done_i → after 20 WAIT cycles RESULT reads 0x7FC00000, FLAGS=0x10, STATUS[18]=1. Without the macro, busy stays 1.
